pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the five-stage core. It decides each cycle whether IF, IF/ID and ID/EX advance, hold, or take a bubble, and it drives the valid input of the ID/EX pipeline register.
- It resolves load-use data hazards, EX-resolved control hazards (pc_sel) and data-memory wait states.
- It keeps a shadow scoreboard of the instruction in EX, a freeze FSM with timeout, and performance counters.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before err_timeout sets (1..2^16-1)
CNT_W, 32, width of performance counters

Ports:
sys_clk  in  1  clock, all state on rising edge
sys_rst  in  1  reset, synchronous, active-low (sys_rst==0 resets on the clock edge)
id_valid  in  1  ID stage holds a valid instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
id_rs1_used  in  1  rs1 is read by the ID instruction
id_rs2_used  in  1  rs2 is read by the ID instruction
id_rd  in  5  ID destination register
id_reg_write  in  1  ID instruction writes rd
id_is_load  in  1  ID instruction is a load (wb_select = memory)
ex_pc_sel  in  1  taken branch/jump resolved in EX
dmem_req  in  1  MEM stage has an active dmem access
dmem_ready  in  1  dmem completes the access this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  squash IF/ID (load NOP)
idex_valid  out  1  valid into ID/EX; 0 = bubble
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB
err_timeout  out  1  sticky dmem timeout flag
stall_cycles  out  CNT_W  count of cycles with pc_stall=1
flush_count  out  CNT_W  count of flush events

Behaviour:
- FSM states are RUN and MEM_WAIT, encoded as 1 bit. Reset state is RUN.
- Reset values: all scoreboard fields 0, both counters 0, err_timeout 0, wait counter 0.
- Outputs decode combinationally from the current state, the scoreboard and the inputs, so control applies in the same cycle.
- During reset the outputs are the RUN decode of the cleared state: idex_valid = id_valid, all stalls 0.

Priority, highest first:
1. Freeze: asserted when dmem_req & ~dmem_ready.
   - pipe_freeze=1, pc_stall=1, ifid_stall=1, idex_valid=0, ifid_flush=0.
   - FSM moves to or stays in MEM_WAIT.
   - The scoreboard does not advance.
   - In the cycle dmem_ready=1, freeze drops and the FSM returns to RUN.
2. Control hazard: ex_pc_sel=1 and not frozen.
   - ifid_flush=1, idex_valid=0; stalls 0.
   - flush_count increments by 1.
   - Overrides load-use, because the ID instruction is squashed.
   - ex_pc_sel raised during a freeze is acted on in the first unfrozen cycle; the frozen EX instruction keeps it asserted.
3. Load-use hazard: all of the following hold.
   - The EX scoreboard entry has valid=1, is_load=1 and rd!=0.
   - id_valid=1.
   - (id_rs1_used & rs1==sb_rd) or (id_rs2_used & rs2==sb_rd).
   - Response: pc_stall=1, ifid_stall=1, idex_valid=0 for exactly one cycle. On the next cycle the EX entry holds the bubble, so the hazard clears and forwarding covers the remaining distance.
4. Otherwise: idex_valid = id_valid; all other controls 0.

Scoreboard (EX entry {valid, rd, is_load}):
- Updates on every unfrozen cycle to {idex_valid & id_reg_write, id_rd, id_is_load}.
- A bubble or flush writes valid=0.

Wait counter and timeout:
- Increments while in MEM_WAIT, saturates at MEM_TIMEOUT, and clears in RUN.
- Reaching MEM_TIMEOUT sets err_timeout. err_timeout clears only on reset.
- The freeze itself continues until dmem_ready.

Performance counters:
- stall_cycles and flush_count wrap modulo 2^CNT_W.
- Reset mid-freeze returns to RUN with all outputs released on the next cycle.

Decomposition:
- Shared package para.v, added alongside `width:
  - state encodings ST_RUN, ST_MEM_WAIT
  - REG_X0 = 5'd0
  - WB_SEL_MEM encoding used to derive is_load
- One sub-module, hazard_scoreboard: holds the EX entry register and produces the load-use compare. The FSM, counters and priority decode stay in the top.

Test Plan:
- Load-use: lw x5 then add x6,x5,x7 → one cycle with pc_stall=ifid_stall=1, idex_valid=0; the next cycle idex_valid=1; stall_cycles=1.
- x0 and unused source: lw x0 then add x6,x0,x0, and lw x5 with rs2=x5 but rs2_used=0 → no stall.
- Branch flush: ex_pc_sel=1 for one cycle → ifid_flush=1, idex_valid=0, flush_count=1. With a simultaneous load-use condition, flush wins and there is no stall.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 → pipe_freeze=1 for 3 cycles and the scoreboard is unchanged. A pending ex_pc_sel flushes in the release cycle.
- Timeout: MEM_TIMEOUT=4, ready held low for 6 cycles → err_timeout rises after the 4th wait cycle and stays 1 after ready. Reset (sys_rst=0 for one edge) clears it and the counters.
- Counter wrap: CNT_W=4, 17 load-use stalls → stall_cycles=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_hazard_ctrl_pkg;

   // Controller FSM state, one bit wide.
   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } ctrl_state_e;

   // Architectural zero register; never a real producer.
   localparam logic [4:0] REG_X0 = 5'd0;

   // Writeback select encodings; a load is an instruction whose wb_select is memory.
   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   // Shadow copy of the instruction currently sitting in EX.
   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
   } ex_entry_t;

   // True when a used source register matches the given destination.
   function automatic logic src_hit(input logic used, input logic [4:0] rs, input logic [4:0] rd);
      return used & (rs == rd);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if;
   logic       id_valid;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] id_rd;
   logic       id_reg_write;
   logic       id_is_load;
   logic       ex_pc_sel;
   logic       dmem_req;
   logic       dmem_ready;
   logic       pc_stall;
   logic       ifid_stall;
   logic       ifid_flush;
   logic       idex_valid;
   logic       pipe_freeze;

   // Datapath side: supplies stage status, receives sequencing controls.
   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_reg_write, id_is_load, ex_pc_sel, dmem_req, dmem_ready,
      input  pc_stall, ifid_stall, ifid_flush, idex_valid, pipe_freeze
   );

   // Controller side.
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd,
             id_reg_write, id_is_load, ex_pc_sel, dmem_req, dmem_ready,
      output pc_stall, ifid_stall, ifid_flush, idex_valid, pipe_freeze
   );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_scoreboard.sv
// EX-stage shadow entry and the load-use comparison against the ID sources.
module hazard_scoreboard
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       advance,
   input  ex_entry_t  wr_entry,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_rs1_used,
   input  logic       id_rs2_used,
   output logic       load_use
);

   ex_entry_t ent_r;
   logic      src_match_s;

   // EX entry follows ID/EX on every unfrozen cycle; holds while frozen.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         ent_r <= '0;
      end else if (advance) begin
         ent_r <= wr_entry;
      end else begin
         ent_r <= ent_r;
      end
   end

   assign src_match_s = src_hit(id_rs1_used, id_rs1, ent_r.rd) |
                        src_hit(id_rs2_used, id_rs2, ent_r.rd);

   // A load to x0 produces nothing, so it never forces a stall.
   assign load_use = ent_r.valid & ent_r.is_load & (ent_r.rd != REG_X0) &
                     id_valid & src_match_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: freeze, flush and load-use stall decode,
// dmem wait timeout and performance counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
)(
   input  logic             sys_clk,
   input  logic             sys_rst,
   pipe_hazard_ctrl_if.slave bus,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);

   ctrl_state_e      state_r;
   ctrl_state_e      next_state_s;
   logic [15:0]      wait_cnt_r;
   logic             err_timeout_r;
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] flush_cnt_r;

   logic             freeze_s;
   logic             load_use_s;
   logic             pc_stall_s;
   logic             ifid_stall_s;
   logic             ifid_flush_s;
   logic             idex_valid_s;
   ex_entry_t        sb_wr_s;

   // Memory wait is the only source of a freeze; reset releases it immediately.
   assign freeze_s = sys_rst & bus.dmem_req & ~bus.dmem_ready;

   // Next-state logic for the RUN / MEM_WAIT freeze FSM.
   always_comb begin
      next_state_s = ST_RUN;
      case (state_r)
         ST_RUN: begin
            if (freeze_s) begin
               next_state_s = ST_MEM_WAIT;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (freeze_s) begin
               next_state_s = ST_MEM_WAIT;
            end else begin
               next_state_s = ST_RUN;
            end
         end
         default: next_state_s = ST_RUN;
      endcase
   end

   // Priority decode: freeze, then EX redirect, then load-use, then pass-through.
   always_comb begin
      pc_stall_s   = 1'b0;
      ifid_stall_s = 1'b0;
      ifid_flush_s = 1'b0;
      idex_valid_s = bus.id_valid;
      if (!sys_rst) begin
         idex_valid_s = bus.id_valid;
      end else if (freeze_s) begin
         pc_stall_s   = 1'b1;
         ifid_stall_s = 1'b1;
         idex_valid_s = 1'b0;
      end else if (bus.ex_pc_sel) begin
         ifid_flush_s = 1'b1;
         idex_valid_s = 1'b0;
      end else if (load_use_s) begin
         pc_stall_s   = 1'b1;
         ifid_stall_s = 1'b1;
         idex_valid_s = 1'b0;
      end else begin
         idex_valid_s = bus.id_valid;
      end
   end

   assign sb_wr_s = '{valid:   idex_valid_s & bus.id_reg_write,
                      rd:      bus.id_rd,
                      is_load: bus.id_is_load};

   hazard_scoreboard u_scoreboard (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .advance     (~freeze_s),
      .wr_entry    (sb_wr_s),
      .id_valid    (bus.id_valid),
      .id_rs1      (bus.id_rs1),
      .id_rs2      (bus.id_rs2),
      .id_rs1_used (bus.id_rs1_used),
      .id_rs2_used (bus.id_rs2_used),
      .load_use    (load_use_s)
   );

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Consecutive wait-cycle counter with saturation and sticky timeout flag.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         wait_cnt_r    <= 16'd0;
         err_timeout_r <= 1'b0;
      end else if (next_state_s == ST_MEM_WAIT) begin
         if (wait_cnt_r < TIMEOUT_C) begin
            wait_cnt_r <= wait_cnt_r + 16'd1;
         end else begin
            wait_cnt_r <= wait_cnt_r;
         end
         if (wait_cnt_r >= (TIMEOUT_C - 16'd1)) begin
            err_timeout_r <= 1'b1;
         end else begin
            err_timeout_r <= err_timeout_r;
         end
      end else begin
         wait_cnt_r    <= 16'd0;
         err_timeout_r <= err_timeout_r;
      end
   end

   // Wrapping performance counters for stall cycles and redirect flushes.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         stall_cnt_r <= '0;
         flush_cnt_r <= '0;
      end else begin
         if (pc_stall_s) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (ifid_flush_s) begin
            flush_cnt_r <= flush_cnt_r + CNT_W'(1'b1);
         end else begin
            flush_cnt_r <= flush_cnt_r;
         end
      end
   end

   assign bus.pc_stall    = pc_stall_s;
   assign bus.ifid_stall  = ifid_stall_s;
   assign bus.ifid_flush  = ifid_flush_s;
   assign bus.idex_valid  = idex_valid_s;
   assign bus.pipe_freeze = freeze_s;
   assign err_timeout     = err_timeout_r;
   assign stall_cycles    = stall_cnt_r;
   assign flush_count     = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b0;
   logic             err_timeout;
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] flush_count;
   logic [4:0]       ctl;

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .bus          (bus),
      .err_timeout  (err_timeout),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   always #5 sys_clk = ~sys_clk;

   // Control vector: {pc_stall, ifid_stall, ifid_flush, idex_valid, pipe_freeze}
   assign ctl = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush, bus.idex_valid, bus.pipe_freeze};

   task automatic next_cycle();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic rw, input logic ld);
      bus.id_valid     = v;
      bus.id_rs1       = r1;
      bus.id_rs2       = r2;
      bus.id_rs1_used  = u1;
      bus.id_rs2_used  = u2;
      bus.id_rd        = rd;
      bus.id_reg_write = rw;
      bus.id_is_load   = ld;
   endtask

   task automatic test_reset();
      sys_rst = 1'b0;
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0);
      bus.ex_pc_sel = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL reset_ctl got %b exp %b", ctl, 5'b00010); end
      next_cycle();
      @(negedge sys_clk);
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
      checks++; if (flush_count !== 4'd0) begin errors++; $display("FAIL reset_flush got %0d exp 0", flush_count); end
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_timeout); end
      next_cycle();
      sys_rst = 1'b1;
   endtask

   task automatic test_load_use();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5,0(x1)
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL lu_load got %b exp %b", ctl, 5'b00010); end
      next_cycle();
      set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x5,x7
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL lu_stall got %b exp %b", ctl, 5'b11000); end
      next_cycle();
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL lu_release got %b exp %b", ctl, 5'b00010); end
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", stall_cycles); end
      next_cycle();
   endtask

   task automatic test_no_stall();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);   // lw x0
      next_cycle();
      set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // add x6,x0,x0
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL x0_nostall got %b exp %b", ctl, 5'b00010); end
      next_cycle();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
      next_cycle();
      set_id(1'b1, 5'd3, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0);   // rs2=x5 unused
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL unused_nostall got %b exp %b", ctl, 5'b00010); end
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL nostall_count got %0d exp 1", stall_cycles); end
      next_cycle();
   endtask

   task automatic test_branch_flush();
      set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      bus.ex_pc_sel = 1'b1;
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00100) begin errors++; $display("FAIL br_flush got %b exp %b", ctl, 5'b00100); end
      next_cycle();
      bus.ex_pc_sel = 1'b0;
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
      @(negedge sys_clk);
      checks++; if (flush_count !== 4'd1) begin errors++; $display("FAIL br_count1 got %0d exp 1", flush_count); end
      next_cycle();
      set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);   // consumer, redirect same cycle
      bus.ex_pc_sel = 1'b1;
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00100) begin errors++; $display("FAIL br_over_lu got %b exp %b", ctl, 5'b00100); end
      next_cycle();
      bus.ex_pc_sel = 1'b0;
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00010) begin errors++; $display("FAIL br_bubble got %b exp %b", ctl, 5'b00010); end
      checks++; if (flush_count !== 4'd2) begin errors++; $display("FAIL br_count2 got %0d exp 2", flush_count); end
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL br_nostall got %0d exp 1", stall_cycles); end
      next_cycle();
   endtask

   task automatic test_mem_wait();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);   // lw x5
      next_cycle();
      set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
      bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge sys_clk);
         checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL mw_freeze%0d got %b exp %b", i, ctl, 5'b11001); end
         next_cycle();
      end
      bus.dmem_ready = 1'b1;
      @(negedge sys_clk);
      // scoreboard still holds the load, so the consumer stalls once now
      checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL mw_sb_hold got %b exp %b", ctl, 5'b11000); end
      next_cycle();
      bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
      @(negedge sys_clk);
      checks++; if (stall_cycles !== 4'd5) begin errors++; $display("FAIL mw_count got %0d exp 5", stall_cycles); end
      next_cycle();
      set_id(1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);
      bus.ex_pc_sel = 1'b1; bus.dmem_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge sys_clk);
         checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL mw_pend%0d got %b exp %b", i, ctl, 5'b11001); end
         next_cycle();
      end
      bus.dmem_ready = 1'b1;
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00100) begin errors++; $display("FAIL mw_release_flush got %b exp %b", ctl, 5'b00100); end
      next_cycle();
      bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0; bus.ex_pc_sel = 1'b0;
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL mw_idle got %b exp %b", ctl, 5'b00000); end
      checks++; if (stall_cycles !== 4'd7) begin errors++; $display("FAIL mw_stall_total got %0d exp 7", stall_cycles); end
      checks++; if (flush_count !== 4'd3) begin errors++; $display("FAIL mw_flush_total got %0d exp 3", flush_count); end
      next_cycle();
   endtask

   task automatic test_timeout();
      bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge sys_clk);
         checks++; if (ctl !== 5'b11001) begin errors++; $display("FAIL to_freeze%0d got %b exp %b", i, ctl, 5'b11001); end
         next_cycle();
         if (i == 2) begin
            checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", err_timeout); end
         end else if (i == 3) begin
            checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", err_timeout); end
         end
      end
      bus.dmem_ready = 1'b1;
      @(negedge sys_clk);
      checks++; if (ctl !== 5'b00000) begin errors++; $display("FAIL to_release got %b exp %b", ctl, 5'b00000); end
      next_cycle();
      bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0;
      @(negedge sys_clk);
      checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", err_timeout); end
      checks++; if (stall_cycles !== 4'd13) begin errors++; $display("FAIL to_stall got %0d exp 13", stall_cycles); end
      next_cycle();
      sys_rst = 1'b0;
      next_cycle();
      sys_rst = 1'b1;
      @(negedge sys_clk);
      checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_rst_err got %b exp 0", err_timeout); end
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL to_rst_stall got %0d exp 0", stall_cycles); end
      checks++; if (flush_count !== 4'd0) begin errors++; $display("FAIL to_rst_flush got %0d exp 0", flush_count); end
      next_cycle();
   endtask

   task automatic test_counter_wrap();
      for (int n = 1; n <= 17; n++) begin
         set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
         next_cycle();
         set_id(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
         @(negedge sys_clk);
         checks++; if (ctl !== 5'b11000) begin errors++; $display("FAIL wrap_stall%0d got %b exp %b", n, ctl, 5'b11000); end
         next_cycle();
         next_cycle();
         if (n == 16) begin
            checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL wrap_16 got %0d exp 0", stall_cycles); end
         end
      end
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL wrap_17 got %0d exp 1", stall_cycles); end
   endtask

   initial begin
      #1;
      test_reset();
      test_load_use();
      test_no_stall();
      test_branch_flush();
      test_mem_wait();
      test_timeout();
      test_counter_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule
